// File: rtl/nibble_add_sched_pkg.sv
// -----------------------------------------------------------------------------
// nibble_add_sched_pkg
// Shared definitions for the nibble-serial add scheduler.
//   state_e  : scheduler FSM encoding (IDLE / ADD / DONE)
//   ID_REQ*  : requester identifiers carried on resp_id
//   NIB_W    : width of the shared adder slice
// -----------------------------------------------------------------------------
package nibble_add_sched_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/nibble_adder.sv
// -----------------------------------------------------------------------------
// nibble_adder
// Combinational NIB_W-bit adder with carry in/out; the single arithmetic
// resource that the scheduler time-shares between requesters.
// Ports:
//   a, b  in  NIB_W  operand slices
//   cin   in  1      carry-in
//   s     out NIB_W  sum slice
//   cout  out 1      carry-out
// -----------------------------------------------------------------------------
module nibble_adder
   import nibble_add_sched_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout
);

   logic [NIB_W:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
   end

   assign s    = total[NIB_W-1:0];
   assign cout = total[NIB_W];

endmodule

// File: rtl/nibble_add_sched.sv
// -----------------------------------------------------------------------------
// nibble_add_sched
// Round-robin scheduler that runs WIDTH-bit additions from two requesters
// through one shared 4-bit adder, one nibble per cycle, LSB nibble first.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid / reqN_ready     request handshake for requester N (0,1)
//   reqN_a, reqN_b, reqN_cin    operands, sampled only on acceptance
//   resp_valid / resp_ready     response handshake
//   resp_sum, resp_cout         (A+B+cin) mod 2^WIDTH and its carry-out
//   resp_id                     requester that issued the result
// -----------------------------------------------------------------------------
module nibble_add_sched
   import nibble_add_sched_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NIB   = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_sum,
   output logic             resp_cout,
   output logic             resp_id
);

   localparam int                IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIB - 1);

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   idx_d;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic [WIDTH-1:0]   sum_d;
   logic               cout_q;
   logic               id_q;
   logic               last_grant_q;
   logic               resp_valid_q;

   logic               grant0;
   logic               grant1;
   logic               xfer0;
   logic               xfer1;
   logic [NIB_W-1:0]   nib_a;
   logic [NIB_W-1:0]   nib_b;
   logic [NIB_W-1:0]   nib_s;
   logic               nib_cout;

   // Round-robin: a lone requester always wins; under contention the one
   // that did not win last time goes next.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || (last_grant_q == ID_REQ1));
      grant1 = req1_valid && (!req0_valid || (last_grant_q == ID_REQ0));
   end

   // Gated by rst_n so readys drop the moment reset is asserted, even while
   // a requester keeps valid high.
   assign req0_ready = rst_n && (state_q == ST_IDLE) && grant0;
   assign req1_ready = rst_n && (state_q == ST_IDLE) && grant1;
   assign xfer0      = req0_valid && req0_ready;
   assign xfer1      = req1_valid && req1_ready;

   // Slice selection for the current nibble step and its write-back.
   always_comb begin
      nib_a = a_q[int'(idx_q)*NIB_W +: NIB_W];
      nib_b = b_q[int'(idx_q)*NIB_W +: NIB_W];
      idx_d = idx_q + 1'b1;
      sum_d = sum_q;
      sum_d[int'(idx_q)*NIB_W +: NIB_W] = nib_s;
   end

   nibble_adder u_nibble_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         carry_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         cout_q       <= 1'b0;
         id_q         <= ID_REQ0;
         last_grant_q <= ID_REQ1;
         resp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (xfer0 || xfer1) begin
                  a_q          <= xfer1 ? req1_a : req0_a;
                  b_q          <= xfer1 ? req1_b : req0_b;
                  carry_q      <= xfer1 ? req1_cin : req0_cin;
                  id_q         <= xfer1 ? ID_REQ1 : ID_REQ0;
                  last_grant_q <= xfer1 ? ID_REQ1 : ID_REQ0;
                  idx_q        <= '0;
                  state_q      <= ST_ADD;
               end
            end
            ST_ADD: begin
               sum_q   <= sum_d;
               carry_q <= nib_cout;
               idx_q   <= idx_d;
               if (idx_q == LAST_IDX) begin
                  cout_q       <= nib_cout;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_sum   = sum_q;
   assign resp_cout  = cout_q;
   assign resp_id    = id_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// -----------------------------------------------------------------------------
// tb_nibble_add_sched
// Directed, table-driven bench for nibble_add_sched (WIDTH=16), plus
// hand-written sequences for contention, backpressure and mid-op reset.
// -----------------------------------------------------------------------------
module tb_nibble_add_sched;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0;
   logic          req0_ready;
   logic [W-1:0]  req0_a = '0;
   logic [W-1:0]  req0_b = '0;
   logic          req0_cin = 1'b0;
   logic          req1_valid = 1'b0;
   logic          req1_ready;
   logic [W-1:0]  req1_a = '0;
   logic [W-1:0]  req1_b = '0;
   logic          req1_cin = 1'b0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [W-1:0]  resp_sum;
   logic          resp_cout;
   logic          resp_id;

   always #5 clk = ~clk;

   nibble_add_sched #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .resp_id    (resp_id)
   );

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic         sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   vec_t vecs [8];

   // Contention operand lists per requester
   logic [W-1:0] c0a [4];
   logic [W-1:0] c0b [4];
   logic         c0c [4];
   logic [W-1:0] c1a [4];
   logic [W-1:0] c1b [4];
   logic         c1c [4];

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   endfunction

   task automatic drive(input logic sel, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin);
      if (sel) begin
         req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
      end else begin
         req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
      end
   endtask

   // Called just after a negedge with the request already driven.
   task automatic wait_grant(input logic sel, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (sel ? req1_ready : req0_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Called right after the transfer posedge; returns the cycle offset from
   // the transfer cycle at which resp_valid is first seen (99 on timeout).
   task automatic wait_resp(output int cyc);
      cyc = 99;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic do_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] es, input logic ec,
                        input string name);
      bit ok;
      int cyc;
      @(negedge clk);
      drive(~sel, 1'b0, '0, '0, 1'b0);
      drive(sel, 1'b1, a, b, cin);
      wait_grant(sel, ok);
      chk({name, " grant"}, 32'(ok), 32'd1);
      if (!ok) begin
         drive(sel, 1'b0, '0, '0, 1'b0);
         return;
      end
      @(posedge clk);
      #1;
      // Scramble operands after acceptance; they must not affect the result.
      drive(sel, 1'b0, ~a, b ^ 16'h5A5A, ~cin);
      wait_resp(cyc);
      chk({name, " latency"}, 32'(cyc), 32'd5);
      chk({name, " sum"}, 32'(resp_sum), 32'(es));
      chk({name, " cout"}, 32'(resp_cout), 32'(ec));
      chk({name, " id"}, 32'(resp_id), 32'(sel));
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk({name, " valid_drop"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int cyc;
      int i0;
      int i1;
      logic g;
      logic [W:0] exp;

      vecs[0] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
      vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[7] = '{1'b1, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

      c0a = '{16'h0001, 16'h1000, 16'hFFFF, 16'h7FFF};
      c0b = '{16'h0002, 16'h2000, 16'h0000, 16'h0001};
      c0c = '{1'b0, 1'b1, 1'b1, 1'b0};
      c1a = '{16'h0010, 16'hF0F0, 16'h8001, 16'h0003};
      c1b = '{16'h0020, 16'h0F0F, 16'h8001, 16'h0004};
      c1c = '{1'b0, 1'b1, 1'b0, 1'b1};

      // Reset with both requesters already valid
      drive(1'b0, 1'b1, c0a[0], c0b[0], c0c[0]);
      drive(1'b1, 1'b1, c1a[0], c1b[0], c1c[0]);
      resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_sum", 32'(resp_sum), 32'd0);
      chk("rst resp_cout", 32'(resp_cout), 32'd0);
      chk("rst resp_id", 32'(resp_id), 32'd0);
      chk("rst req0_ready", 32'(req0_ready), 32'd0);
      chk("rst req1_ready", 32'(req1_ready), 32'd0);

      // Contention: both valid from reset release, grants must alternate 0,1,...
      @(negedge clk);
      rst_n = 1'b1;
      i0 = 0;
      i1 = 0;
      for (int n = 0; n < 8; n++) begin
         if (i0 < 4) drive(1'b0, 1'b1, c0a[i0], c0b[i0], c0c[i0]);
         else        drive(1'b0, 1'b0, '0, '0, 1'b0);
         if (i1 < 4) drive(1'b1, 1'b1, c1a[i1], c1b[i1], c1c[i1]);
         else        drive(1'b1, 1'b0, '0, '0, 1'b0);
         ok = 1'b0;
         for (int k = 0; k < 20; k++) begin
            #1;
            if (req0_ready || req1_ready) begin
               ok = 1'b1;
               break;
            end
            @(negedge clk);
         end
         chk("cont grant_seen", 32'(ok), 32'd1);
         if (!ok) break;
         g = req1_ready;
         chk("cont grant_order", 32'(g), 32'(n % 2));
         chk("cont onehot", 32'(req0_ready && req1_ready), 32'd0);
         if (g) exp = model(c1a[i1], c1b[i1], c1c[i1]);
         else   exp = model(c0a[i0], c0b[i0], c0c[i0]);
         @(posedge clk);
         #1;
         if (g) begin
            i1++;
            if (i1 < 4) drive(1'b1, 1'b1, c1a[i1], c1b[i1], c1c[i1]);
            else        drive(1'b1, 1'b0, '0, '0, 1'b0);
         end else begin
            i0++;
            if (i0 < 4) drive(1'b0, 1'b1, c0a[i0], c0b[i0], c0c[i0]);
            else        drive(1'b0, 1'b0, '0, '0, 1'b0);
         end
         wait_resp(cyc);
         chk("cont latency", 32'(cyc), 32'd5);
         chk("cont sum", 32'(resp_sum), 32'(exp[W-1:0]));
         chk("cont cout", 32'(resp_cout), 32'(exp[W]));
         chk("cont id", 32'(resp_id), 32'(g));
         @(negedge clk);
      end
      chk("cont all0_issued", 32'(i0), 32'd4);
      chk("cont all1_issued", 32'(i1), 32'd4);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      resp_ready = 1'b0;

      // Table-driven single-requester vectors
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin,
               vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));
      end

      // Backpressure: hold resp_ready low in DONE while req1 asks
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h0123, 16'h0456, 1'b0);
      wait_grant(1'b0, ok);
      chk("bp grant", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
      wait_resp(cyc);
      chk("bp latency", 32'(cyc), 32'd5);
      drive(1'b1, 1'b1, 16'h0F0F, 16'h00F1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp valid", 32'(resp_valid), 32'd1);
         chk("bp sum", 32'(resp_sum), 32'h0579);
         chk("bp cout", 32'(resp_cout), 32'd0);
         chk("bp id", 32'(resp_id), 32'd0);
         chk("bp readys", 32'({req0_ready, req1_ready}), 32'd0);
         @(negedge clk);
      end
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      resp_ready = 1'b1;
      #1;
      chk("bp valid_at_release", 32'(resp_valid), 32'd1);
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("bp valid_drop", 32'(resp_valid), 32'd0);

      // Reset during the second ADD cycle
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
      wait_grant(1'b0, ok);
      chk("mrst grant", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b1, 1'b1, '0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst resp_valid", 32'(resp_valid), 32'd0);
      chk("mrst req0_ready", 32'(req0_ready), 32'd0);
      chk("mrst req1_ready", 32'(req1_ready), 32'd0);
      chk("mrst resp_sum", 32'(resp_sum), 32'd0);
      chk("mrst resp_cout", 32'(resp_cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, '0, '0, 1'b0);
      drive(1'b1, 1'b1, '0, '0, 1'b0);
      #1;
      chk("mrst prio0", 32'(req0_ready), 32'd1);
      chk("mrst prio1", 32'(req1_ready), 32'd0);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      do_op(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, "post_reset");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/nibble_add_sched.md
Name: nibble_add_sched

Overview:
- Shares one combinational 4-bit ripple adder between two requesters.
- Each request is a WIDTH-bit addition with carry-in. The block arbitrates round-robin between the requesters and runs the add one nibble per cycle, least-significant nibble first, carrying between nibbles.
- Returns a WIDTH-bit sum, the carry-out and the requester ID over a valid/ready response channel.
- Sits between the two arithmetic clients and the single shared adder instance.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived; number of nibble steps per operation. Do not override.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_sum  out  WIDTH  sum.
- resp_cout  out  1  carry-out of the MSB nibble.
- resp_id  out  1  requester that issued this result (0 or 1).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; req0_ready=req1_ready=0; resp_valid=0; resp_sum=0; resp_cout=0; resp_id=0.
  - Nibble index=0; carry register=0; last_grant=1, so requester 0 wins first.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - Arbitration: if only one valid, grant it. If both valid, grant the requester not equal to last_grant.
  - readyN is combinational: 1 only in IDLE for the granted N. A transfer occurs when validN and readyN are both 1.
  - On transfer: latch A, B and cin (cin goes into the carry register); record id; last_grant=id; index=0; go to ADD.
  - If neither requester is valid: stay in IDLE.
- ADD:
  - Each cycle, the shared adder gets A[4i+3:4i], B[4i+3:4i] and the carry register.
  - The 4-bit result is written into sum[4i+3:4i]; the carry register takes the adder carry-out; i increments.
  - After step i=NIB-1: resp_cout=final carry; go to DONE.
  - Takes exactly NIB cycles. Requester inputs are ignored, so operand changes after acceptance have no effect.
- DONE:
  - resp_valid=1. resp_sum, resp_cout and resp_id are held stable until resp_ready=1.
  - On the resp handshake: resp_valid goes to 0 next cycle; go to IDLE.
- Latency: transfer at cycle T. resp_valid rises at T+NIB+1 (T+5 for WIDTH=16).
- Throughput: one operation per NIB+2 cycles minimum, since IDLE always costs one cycle.
- Arithmetic:
  - Unsigned modular result.
  - resp_sum = (A+B+cin) mod 2^WIDTH.
  - resp_cout = bit WIDTH of A+B+cin.
- Boundary cases:
  - Both requesters held valid continuously: grants strictly alternate 0,1,0,1.
  - Requester drops valid before being granted: no transfer, no state change.
  - resp_ready held 0: the block stalls in DONE indefinitely; no new grants.
  - resp_ready=1 already on the first DONE cycle: a single-cycle resp_valid pulse is legal.
  - Reset asserted mid-ADD or mid-DONE: the operation is discarded and all outputs return to reset values immediately. After reset release, arbitration restarts with requester 0 priority.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, ADD=2'd1, DONE=2'd2.
  - Requester ID constants.
  - The nibble width constant (4).
- One sub-module: nibble_adder.
  - Combinational; inputs a[3:0], b[3:0], cin; outputs s[3:0], cout.
  - Instantiated once inside nibble_add_sched as the shared resource.

Test Plan:
- Basic add: req0 a=0x00FF b=0x0001 cin=0 → resp_sum=0x0100, cout=0, id=0; resp_valid exactly 5 cycles after the transfer.
- Full carry chain: req1 a=0xFFFF b=0x0001 cin=0 → resp_sum=0x0000, cout=1, id=1. Also a=0x1234 b=0x4321 cin=1 → resp_sum=0x5556, cout=0.
- Contention: both requesters valid from reset release, resp_ready=1, 4 operations each → grant order 0,1,0,1,...; each result's id and sum match its requester's operands; no request dropped.
- Backpressure: resp_ready=0 for 3 cycles in DONE → resp_sum/cout/id stable; req0_ready and req1_ready stay 0; completes on the cycle resp_ready=1.
- Reset mid-operation: assert rst_n=0 at the 2nd ADD cycle → resp_valid=0 and both readys=0 immediately. After release, a new req1-only operation a=0x0F0F b=0x00F1 cin=0 → resp_sum=0x1000, cout=0.
- Operand stability: change req0_a/req0_b during ADD → result reflects only the values latched at acceptance.
